// File: rtl/instr_decode_hazard_if.sv
// Fetch-to-decode handshake plus the registered control bundle that the
// register-read stage latches from the decode stage.
interface instr_decode_hazard_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   instr_valid;
    logic [15:0]            instr;
    logic                   instr_ready;
    logic                   flush;
    logic [3:0]             rs;
    logic [3:0]             rt;
    logic [3:0]             rd;
    logic [7:0]             imm;
    logic                   stall;
    logic                   RegDst;
    logic                   Jump;
    logic                   Branch;
    logic                   MemRead;
    logic                   MemtoReg;
    logic                   MemWrite;
    logic                   ALUSrc;
    logic                   RegWrite;
    logic [1:0]             alu_op;
    logic                   illegal;
    logic [STALL_CNT_W-1:0] stall_count;

    // Fetch / environment side.
    modport master (
        output instr_valid, instr, flush,
        input  instr_ready, rs, rt, rd, imm, stall,
               RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
               alu_op, illegal, stall_count
    );

    // Decode stage side.
    modport slave (
        input  instr_valid, instr, flush,
        output instr_ready, rs, rt, rd, imm, stall,
               RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
               alu_op, illegal, stall_count
    );
endinterface

// File: rtl/instr_decode_hazard.sv
// Decode stage: splits 16-bit instructions into register indices, immediate
// and controls, and holds back readers of registers whose writer is still in
// flight using a per-register countdown scoreboard.
module instr_decode_hazard #(
    parameter int WB_DIST     = 3,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_decode_hazard_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_J    = 4'd9
    } op_e;

    typedef struct packed {
        logic reg_dst;
        logic jump;
        logic branch;
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [7:0] imm;
        ctrl_t      ctrl;
        logic [1:0] alu_op;
    } dec_t;

    op_e        op;
    logic [3:0] fa, fb, fc;
    dec_t       dec, out_q;
    logic       src1_use, src2_use, dst_use, issuable;
    logic [3:0] src1, src2, dst;
    logic       hazard, issue, bump_stall, illegal_d;

    logic [CNT_W-1:0]       sb [16];
    logic [STALL_CNT_W-1:0] stall_count_q;
    logic                   stall_q, illegal_q;

    assign op = op_e'(bus.instr[15:12]);
    assign fa = bus.instr[11:8];
    assign fb = bus.instr[7:4];
    assign fc = bus.instr[3:0];

    // Field split, control generation and source/destination identification.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        dec      = '0;
        src1_use = 1'b0;
        src2_use = 1'b0;
        dst_use  = 1'b0;
        src1     = '0;
        src2     = '0;
        dst      = '0;
        issuable = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.rd = fa; dec.rs = fb; dec.rt = fc;
                dec.ctrl.reg_dst = 1'b1; dec.ctrl.reg_write = 1'b1;
                dec.alu_op = bus.instr[13:12] - 2'd1;
                src1_use = 1'b1; src1 = fb;
                src2_use = 1'b1; src2 = fc;
                dst_use  = 1'b1; dst  = fa;
            end
            OP_ADDI, OP_LW: begin
                dec.rt  = fa; dec.imm = {fb, fc};
                dec.ctrl.alu_src = 1'b1; dec.ctrl.reg_write = 1'b1;
                dec.ctrl.mem_read   = (op == OP_LW);
                dec.ctrl.mem_to_reg = (op == OP_LW);
                src1_use = 1'b1; src1 = fa;
                dst_use  = 1'b1; dst  = fa;
            end
            OP_SW: begin
                dec.rs  = fa; dec.imm = {fb, fc};
                dec.ctrl.alu_src = 1'b1; dec.ctrl.mem_write = 1'b1;
                src1_use = 1'b1; src1 = fa;
            end
            OP_BEQ: begin
                dec.rs  = fa; dec.rt = fb; dec.imm = {4'b0, fc};
                dec.ctrl.branch = 1'b1; dec.alu_op = 2'b01;
                src1_use = 1'b1; src1 = fa;
                src2_use = 1'b1; src2 = fb;
            end
            OP_J: begin
                dec.imm = {fb, fc};
                dec.ctrl.jump = 1'b1;
            end
            default: issuable = 1'b0;
        endcase
    end

    // Hazard detection against pre-edge scoreboard values and the per-edge decision.
    always_comb begin
        hazard     = bus.instr_valid &
                     ((src1_use && sb[src1] != '0) || (src2_use && sb[src2] != '0));
        issue      = bus.instr_valid & ~bus.flush & ~hazard & issuable;
        bump_stall = hazard & ~bus.flush;
        illegal_d  = bus.instr_valid & ~bus.flush & (bus.instr[15:12] >= 4'd10);
    end

    assign bus.instr_ready = ~hazard | bus.flush;

    // Scoreboard: issued destination reloads to WB_DIST, all other live counters count down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counters are real state that gates issue, so they are reset like any register.
            for (int i = 0; i < 16; i++) sb[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                // NOTE: non-blocking updates so every counter sees the same pre-edge values.
                if (issue && dst_use && dst == 4'(i))
                    sb[i] <= CNT_W'(WB_DIST);
                else if (sb[i] != '0)
                    sb[i] <= sb[i] - CNT_W'(1);
            end
        end
    end

    // Output register: decoded bundle on issue, otherwise a zeroed bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            stall_q   <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            out_q     <= issue ? dec : '0;
            stall_q   <= ~issue;
            illegal_q <= illegal_d;
        end
    end

    // Saturating count of bubbles caused by RAW hazards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count_q <= '0;
        else if (bump_stall && stall_count_q != '1)
            stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end

    assign bus.rs          = out_q.rs;
    assign bus.rt          = out_q.rt;
    assign bus.rd          = out_q.rd;
    assign bus.imm         = out_q.imm;
    assign bus.RegDst      = out_q.ctrl.reg_dst;
    assign bus.Jump        = out_q.ctrl.jump;
    assign bus.Branch      = out_q.ctrl.branch;
    assign bus.MemRead     = out_q.ctrl.mem_read;
    assign bus.MemtoReg    = out_q.ctrl.mem_to_reg;
    assign bus.MemWrite    = out_q.ctrl.mem_write;
    assign bus.ALUSrc      = out_q.ctrl.alu_src;
    assign bus.RegWrite    = out_q.ctrl.reg_write;
    assign bus.alu_op      = out_q.alu_op;
    assign bus.stall       = stall_q;
    assign bus.illegal     = illegal_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_instr_decode_hazard.sv
// Bench for the decode/hazard stage: directed scenarios followed by random
// instruction streams, all compared against a time-based reference model.
module tb_instr_decode_hazard;

    localparam int WB_DIST     = 3;
    localparam int STALL_CNT_W = 16;

    logic clk;
    logic rst;

    instr_decode_hazard_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

    instr_decode_hazard #(
        .WB_DIST    (WB_DIST),
        .CNT_W      (2),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected decode of one instruction, straight from the opcode table.
    typedef struct packed {
        logic [3:0] rs, rt, rd;
        logic [7:0] imm;
        logic [7:0] ctrl;   // {RegDst,Jump,Branch,MemRead,MemtoReg,MemWrite,ALUSrc,RegWrite}
        logic [1:0] alu;
        logic       legal;
        logic       s1_use, s2_use, d_use;
        logic [3:0] s1, s2, dst;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: edge index of the most recent issue writing each register.
    int edge_no;
    int last_wr [16];
    int sc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic exp_t ref_decode(input logic [15:0] ins);
        exp_t e;
        int   op;
        logic [3:0] a, b, c;
        e  = '0;
        op = int'(ins[15:12]);
        a  = ins[11:8];
        b  = ins[7:4];
        c  = ins[3:0];
        e.legal = (op >= 1 && op <= 9);
        if (op >= 1 && op <= 4) begin
            e.rd = a; e.rs = b; e.rt = c; e.ctrl = 8'b1000_0001; e.alu = 2'(op - 1);
            e.s1_use = 1; e.s1 = b; e.s2_use = 1; e.s2 = c; e.d_use = 1; e.dst = a;
        end else if (op == 5) begin
            e.rt = a; e.imm = {b, c}; e.ctrl = 8'b0000_0011;
            e.s1_use = 1; e.s1 = a; e.d_use = 1; e.dst = a;
        end else if (op == 6) begin
            e.rt = a; e.imm = {b, c}; e.ctrl = 8'b0001_1011;
            e.s1_use = 1; e.s1 = a; e.d_use = 1; e.dst = a;
        end else if (op == 7) begin
            e.rs = a; e.imm = {b, c}; e.ctrl = 8'b0000_0110;
            e.s1_use = 1; e.s1 = a;
        end else if (op == 8) begin
            e.rs = a; e.rt = b; e.imm = {4'b0, c}; e.ctrl = 8'b0010_0000; e.alu = 2'b01;
            e.s1_use = 1; e.s1 = a; e.s2_use = 1; e.s2 = b;
        end else if (op == 9) begin
            e.imm = {b, c}; e.ctrl = 8'b0100_0000;
        end
        return e;
    endfunction

    function automatic logic reader_blocked(input logic use_it, input logic [3:0] r);
        // A reader at edge t must wait while t - (writer edge) <= WB_DIST.
        return use_it && ((edge_no - last_wr[r]) <= WB_DIST);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) last_wr[i] = -100000;
        sc_m = 0;
    endtask

    // Present one instruction for one edge and compare every output.
    task automatic step(input logic v, input logic [15:0] ins, input logic fl, output logic rdy);
        exp_t e;
        logic hz, iss, ill;
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.flush       = fl;
        e   = ref_decode(ins);
        hz  = v && (reader_blocked(e.s1_use, e.s1) || reader_blocked(e.s2_use, e.s2));
        rdy = !hz || fl;
        iss = v && !fl && !hz && e.legal;
        ill = v && !fl && (ins[15:12] >= 4'd10);
        #1;
        check("instr_ready", 32'(bus.instr_ready), 32'(rdy));
        if (hz && !fl && sc_m != 65535) sc_m++;
        if (iss && e.d_use) last_wr[e.dst] = edge_no;
        edge_no++;
        @(posedge clk);
        #1;
        check("stall", 32'(bus.stall), 32'(!iss));
        check("fields", 32'({bus.rs, bus.rt, bus.rd, bus.imm}),
              iss ? 32'({e.rs, e.rt, e.rd, e.imm}) : 32'd0);
        check("ctrl", 32'({bus.RegDst, bus.Jump, bus.Branch, bus.MemRead, bus.MemtoReg,
                           bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.alu_op}),
              iss ? 32'({e.ctrl, e.alu}) : 32'd0);
        check("illegal", 32'(bus.illegal), 32'(ill));
        check("stall_count", 32'(bus.stall_count), 32'(sc_m));
        @(negedge clk);
    endtask

    // Pulse reset; outputs must clear asynchronously, before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_stall", 32'(bus.stall), 32'd1);
        check("rst_ctrl", 32'({bus.RegDst, bus.Jump, bus.Branch, bus.MemRead, bus.MemtoReg,
                               bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.alu_op, bus.illegal}),
              32'd0);
        check("rst_fields", 32'({bus.rs, bus.rt, bus.rd, bus.imm}), 32'd0);
        check("rst_stall_count", 32'(bus.stall_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic        rdy;
        logic        hold;
        logic        cur_v;
        logic [15:0] cur;
        logic        fl;

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.flush       = 1'b0;
        edge_no         = 0;
        model_reset();
        do_reset();

        // Reset in the middle of a hazard stall: held ADD issues right after.
        step(1, 16'h5405, 0, rdy);
        step(1, 16'h1546, 0, rdy);
        check("c1_held", 32'(rdy), 32'd0);
        do_reset();
        step(1, 16'h1546, 0, rdy);
        check("c1_issue_after_rst", 32'(bus.stall), 32'd0);

        // Simple ADD.
        do_reset();
        step(1, 16'h1123, 0, rdy);
        check("c2_rd_rs_rt", 32'({bus.rd, bus.rs, bus.rt}), 32'h123);

        // ADDI then dependent ADD: three bubbles, issue on the fourth edge.
        do_reset();
        step(1, 16'h5405, 0, rdy);
        for (int i = 0; i < 4; i++) step(1, 16'h1546, 0, rdy);
        check("c3_stall_count", 32'(bus.stall_count), 32'd3);
        check("c3_rd", 32'(bus.rd), 32'd5);

        // SW of a freshly written register stalls; SW of another register does not.
        do_reset();
        step(1, 16'h1123, 0, rdy);
        for (int i = 0; i < 4; i++) step(1, 16'h7105, 0, rdy);
        check("c4_dep_sc", 32'(bus.stall_count), 32'd3);
        do_reset();
        step(1, 16'h1123, 0, rdy);
        step(1, 16'h7205, 0, rdy);
        check("c4_indep_stall", 32'(bus.stall), 32'd0);

        // Flush during the second bubble; the r4 countdown keeps running.
        do_reset();
        step(1, 16'h5405, 0, rdy);
        step(1, 16'h1546, 0, rdy);
        step(1, 16'h1546, 1, rdy);
        check("c5_ready", 32'(rdy), 32'd1);
        check("c5_sc", 32'(bus.stall_count), 32'd1);
        step(1, 16'h1546, 0, rdy);
        check("c5_sc_after", 32'(bus.stall_count), 32'd2);
        step(1, 16'h1546, 0, rdy);
        check("c5_issue", 32'(bus.stall), 32'd0);

        // Illegal opcode bubble, then a jump.
        step(1, 16'hF000, 0, rdy);
        check("c6_illegal", 32'(bus.illegal), 32'd1);
        step(1, 16'h9042, 0, rdy);
        check("c6_jump_imm", 32'({bus.Jump, bus.imm}), 32'h142);

        // Random streams over a small register set so hazards are frequent.
        hold  = 1'b0;
        cur_v = 1'b0;
        cur   = '0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset();
                hold = 1'b0;
            end
            if (!hold) begin
                cur_v = ($urandom_range(0, 9) != 0);
                cur   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
                if ($urandom_range(0, 3) == 0) cur[7:0] = 8'($urandom);
            end
            fl = ($urandom_range(0, 11) == 0);
            step(cur_v, cur, fl, rdy);
            hold = cur_v && !rdy;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
